// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
// Fetch stage for the five-stage MIPS pipeline. It owns the fetch PC, issues
// requests to instruction memory, and buffers the returned words together
// with their PC in a DEPTH-entry FIFO. ID takes words from the FIFO head
// through a valid/ready handshake. A branch/jump redirect flushes the buffer
// and discards every response that is still in flight.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   redirect, redirect_pc            taken branch/jump and its target
//   imem_req, imem_addr, imem_gnt    request channel to instruction memory
//   imem_rvalid, imem_rdata          in-order response channel
//   inst_valid, inst_ready           FIFO head handshake towards ID
//   inst, inst_pc, inst_pc4          head word, its PC and PC+4
//   fifo_count                       current FIFO occupancy
//   err_resp                         sticky: response with nothing in flight
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [DATA_W-1:0]      imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [DATA_W-1:0]      inst,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic [ADDR_W-1:0]      inst_pc4,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_resp
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [CW-1:0]     inflight_r;
    logic [CW-1:0]     drop_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     tag_wr_ptr_r;
    logic [PW-1:0]     tag_rd_ptr_r;
    logic              err_r;

    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
    logic [ADDR_W-1:0] tag_mem_r  [DEPTH];

    logic [CW-1:0]     live_s;
    logic [OW-1:0]     occupancy_s;
    logic              imem_req_s;
    logic              issue_s;
    logic              rv_ok_s;
    logic              discard_s;
    logic              push_s;
    logic              pop_s;
    logic              unused_pc_bits_s;

    // The low two bits of the redirect target are forced to zero.
    assign unused_pc_bits_s = ^redirect_pc[1:0];

    // Credit check and per-cycle event decode.
    always_comb begin
        live_s      = inflight_r - drop_r;
        // A request is allowed only if every live response already has a
        // FIFO slot reserved, so a push can never hit a full FIFO.
        occupancy_s = {1'b0, count_r} + {1'b0, live_s};
        imem_req_s  = reset_n & ~redirect
                    & (occupancy_s < OW'(DEPTH))
                    & (inflight_r < CW'(DEPTH));
        issue_s     = imem_req_s & imem_gnt;
        // A response with nothing outstanding is an error and is ignored.
        rv_ok_s     = imem_rvalid & (inflight_r != '0);
        discard_s   = rv_ok_s & (drop_r != '0);
        push_s      = rv_ok_s & ~redirect & (drop_r == '0);
        pop_s       = (count_r != '0) & inst_ready & ~redirect;
    end

    // PC, credit counters, FIFO/tag pointers and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r   <= RESET_PC;
            inflight_r   <= '0;
            drop_r       <= '0;
            count_r      <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            tag_wr_ptr_r <= '0;
            tag_rd_ptr_r <= '0;
            err_r        <= 1'b0;
        end else if (redirect) begin
            // Everything still outstanding after this cycle belongs to the
            // old path and must be dropped on return.
            fetch_pc_r   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_r   <= inflight_r - CW'(rv_ok_s);
            drop_r       <= inflight_r - CW'(rv_ok_s);
            count_r      <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            tag_wr_ptr_r <= '0;
            tag_rd_ptr_r <= '0;
            err_r        <= err_r | (imem_rvalid & ~rv_ok_s);
        end else begin
            if (issue_s) begin
                fetch_pc_r   <= fetch_pc_r + ADDR_W'(3'd4);
                tag_wr_ptr_r <= tag_wr_ptr_r + PW'(1'b1);
            end else begin
                fetch_pc_r   <= fetch_pc_r;
                tag_wr_ptr_r <= tag_wr_ptr_r;
            end
            if (push_s) begin
                wr_ptr_r     <= wr_ptr_r + PW'(1'b1);
                tag_rd_ptr_r <= tag_rd_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_r     <= wr_ptr_r;
                tag_rd_ptr_r <= tag_rd_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            inflight_r <= inflight_r + CW'(issue_s) - CW'(rv_ok_s);
            drop_r     <= drop_r - CW'(discard_s);
            count_r    <= count_r + CW'(push_s) - CW'(pop_s);
            err_r      <= err_r | (imem_rvalid & ~rv_ok_s);
        end
    end

    // Tag queue and FIFO storage; contents are qualified by the pointers and
    // counters above, so no reset is needed.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            tag_mem_r[tag_wr_ptr_r] <= fetch_pc_r;
        end
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= imem_rdata;
            pc_mem_r[wr_ptr_r]   <= tag_mem_r[tag_rd_ptr_r];
        end
    end

    assign imem_req   = imem_req_s;
    assign imem_addr  = fetch_pc_r;
    assign inst_valid = (count_r != '0);
    assign inst       = data_mem_r[rd_ptr_r];
    assign inst_pc    = pc_mem_r[rd_ptr_r];
    assign inst_pc4   = pc_mem_r[rd_ptr_r] + ADDR_W'(3'd4);
    assign fifo_count = count_r;
    assign err_resp   = err_r;

endmodule
